// File: rtl/mmio_ports_if.sv
// CPU-side memory bus, RAM pass-through and per-channel output streams of mmio_ports.
// master = CPU/consumer side, slave = the port block itself.
interface mmio_ports_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int N_CH   = 2
);
    logic [ADDR_W-1:0]      mem_addr;
    logic                   mem_wr_en;
    logic [DATA_W-1:0]      mem_wr_data;
    logic [DATA_W-1:0]      mem_rd_data;
    logic                   ram_wr_en;
    logic [DATA_W-1:0]      ram_rd_data;
    logic                   stall;
    logic [N_CH-1:0]        out_valid;
    logic [N_CH*DATA_W-1:0] out_data;
    logic [N_CH-1:0]        out_ready;

    modport master (
        output mem_addr, mem_wr_en, mem_wr_data, ram_rd_data, out_ready,
        input  mem_rd_data, ram_wr_en, stall, out_valid, out_data
    );

    modport slave (
        input  mem_addr, mem_wr_en, mem_wr_data, ram_rd_data, out_ready,
        output mem_rd_data, ram_wr_en, stall, out_valid, out_data
    );
endinterface

// File: rtl/mmio_ports.sv
// Memory-mapped output ports: N_CH write-only FIFO channels plus FULL/EMPTY status
// registers decoded above BASE; all other addresses pass through to system RAM.
module mmio_ports #(
    parameter int                DATA_W = 8,
    parameter int                ADDR_W = 8,
    parameter int                N_CH   = 2,
    parameter int                DEPTH  = 4,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'('hF8)
) (
    input  logic        clk,
    input  logic        rst,
    mmio_ports_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDR_W-1:0] FULL_ADDR  = BASE + ADDR_W'(N_CH);
    localparam logic [ADDR_W-1:0] EMPTY_ADDR = BASE + ADDR_W'(N_CH + 1);

    logic [PW-1:0]     rd_ptr_q [N_CH];
    logic [PW-1:0]     rd_ptr_d [N_CH];
    logic [PW-1:0]     wr_ptr_q [N_CH];
    logic [PW-1:0]     wr_ptr_d [N_CH];
    logic [CW-1:0]     count_q  [N_CH];
    logic [CW-1:0]     count_d  [N_CH];
    logic [DATA_W-1:0] mem_q    [N_CH][DEPTH];
    logic [DATA_W-1:0] mem_d    [N_CH][DEPTH];

    logic              hit;
    logic              is_ch;
    logic [ADDR_W-1:0] ch_off;
    logic [N_CH-1:0]   full;
    logic [N_CH-1:0]   empty;
    logic [N_CH-1:0]   push;
    logic [N_CH-1:0]   pop;

    always_comb begin
        ch_off = bus.mem_addr - BASE;
        hit    = (bus.mem_addr >= BASE) && (bus.mem_addr <= EMPTY_ADDR);
        is_ch  = hit && (ch_off < ADDR_W'(N_CH));
    end

    // A full channel never pushes, even when its consumer pops in the same cycle;
    // the CPU is held off and retries once the slot is visibly free.
    always_comb begin
        bus.stall = 1'b0;
        full      = '0;
        empty     = '0;
        push      = '0;
        pop       = '0;
        for (int c = 0; c < N_CH; c++) begin
            full[c]  = (count_q[c] == CW'(DEPTH));
            empty[c] = (count_q[c] == '0);
            pop[c]   = !empty[c] && bus.out_ready[c];
            if (bus.mem_wr_en && is_ch && (ch_off == ADDR_W'(c))) begin
                if (full[c]) bus.stall = 1'b1;
                else         push[c]   = 1'b1;
            end
        end
    end

    always_comb begin
        bus.ram_wr_en = bus.mem_wr_en && !hit;
        if (bus.mem_addr == FULL_ADDR)
            bus.mem_rd_data = DATA_W'(full);
        else if (bus.mem_addr == EMPTY_ADDR)
            bus.mem_rd_data = DATA_W'(empty);
        else if (is_ch)
            bus.mem_rd_data = '0;
        else
            bus.mem_rd_data = bus.ram_rd_data;
    end

    always_comb begin
        bus.out_valid = ~empty;
        bus.out_data  = '0;
        for (int c = 0; c < N_CH; c++)
            bus.out_data[c*DATA_W +: DATA_W] = mem_q[c][rd_ptr_q[c]];
    end

    always_comb begin
        mem_d = mem_q;
        for (int c = 0; c < N_CH; c++) begin
            rd_ptr_d[c] = rd_ptr_q[c];
            wr_ptr_d[c] = wr_ptr_q[c];
            count_d[c]  = count_q[c];
            if (push[c]) begin
                mem_d[c][wr_ptr_q[c]] = bus.mem_wr_data;
                wr_ptr_d[c] = wr_ptr_q[c] + PW'(1);
            end
            if (pop[c])
                rd_ptr_d[c] = rd_ptr_q[c] + PW'(1);
            case ({push[c], pop[c]})
                2'b10:   count_d[c] = count_q[c] + CW'(1);
                2'b01:   count_d[c] = count_q[c] - CW'(1);
                default: count_d[c] = count_q[c];
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is never reset; an empty FIFO's contents are never observed as valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_mmio_ports.sv
// Directed bench for mmio_ports with default parameters (N_CH=2, DEPTH=4, BASE=F8).
module tb_mmio_ports;
    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    mmio_ports_if #(.DATA_W(8), .ADDR_W(8), .N_CH(2)) bus ();

    mmio_ports #(.DATA_W(8), .ADDR_W(8), .N_CH(2), .DEPTH(4), .BASE(8'hF8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] addr, input logic [7:0] exp);
        bus.mem_addr  = addr;
        bus.mem_wr_en = 1'b0;
        #1;
        chk(tag, 32'(bus.mem_rd_data), 32'(exp));
    endtask

    function automatic logic [7:0] ch_data(input int c);
        return bus.out_data[c*8 +: 8];
    endfunction

    logic       s_push [11] = '{1,1,1,1,1,1,1,0,0,0,0};
    logic [7:0] s_data [11] = '{8'h41,8'h42,8'h43,8'h44,8'h45,8'h46,8'h47,8'h00,8'h00,8'h00,8'h00};
    logic       s_rdy  [11] = '{1,1,1,0,0,1,0,1,1,1,1};
    logic       s_val  [11] = '{0,1,1,1,1,1,1,1,1,1,1};
    logic [7:0] s_head [11] = '{8'h00,8'h41,8'h42,8'h43,8'h43,8'h43,8'h44,8'h44,8'h45,8'h46,8'h47};

    initial begin
        rst             = 1'b1;
        bus.mem_addr    = 8'h00;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = 8'h00;
        bus.ram_rd_data = 8'hC3;
        bus.out_ready   = 2'b00;
        #12;
        // reset state
        chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        rd_chk("rst_full", 8'hFA, 8'h00);
        rd_chk("rst_empty", 8'hFB, 8'h03);
        rst = 1'b0;
        tick();

        // three writes to ch0 then drain
        bus.mem_addr = 8'hF8;
        bus.mem_wr_en = 1'b1;
        bus.mem_wr_data = 8'h11;
        #1;
        chk("ch0_ram_wr_en", 32'(bus.ram_wr_en), 32'h0);
        chk("ch0_stall", 32'(bus.stall), 32'h0);
        tick();
        bus.mem_wr_data = 8'h22;
        tick();
        bus.mem_wr_data = 8'h33;
        tick();
        bus.mem_wr_en = 1'b0;
        #1;
        chk("ch0_valid3", 32'(bus.out_valid), 32'h1);
        bus.out_ready = 2'b01;
        #1;
        chk("ch0_head0", 32'(ch_data(0)), 32'h11);
        tick();
        chk("ch0_head1", 32'(ch_data(0)), 32'h22);
        tick();
        chk("ch0_head2", 32'(ch_data(0)), 32'h33);
        chk("ch0_valid_last", 32'(bus.out_valid), 32'h1);
        tick();
        chk("ch0_drained", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 2'b00;

        // fill ch1, stall on 5th write until a pop
        bus.mem_addr = 8'hF9;
        bus.mem_wr_en = 1'b1;
        bus.mem_wr_data = 8'hAA; #1; chk("fill_stall0", 32'(bus.stall), 32'h0); tick();
        bus.mem_wr_data = 8'hBB; #1; chk("fill_stall1", 32'(bus.stall), 32'h0); tick();
        bus.mem_wr_data = 8'hCC; tick();
        bus.mem_wr_data = 8'hDD; tick();
        bus.mem_wr_en = 1'b0;
        rd_chk("ch1_full_reg", 8'hFA, 8'h02);
        chk("ch1_valid", 32'(bus.out_valid), 32'h2);
        bus.mem_addr = 8'hF9;
        bus.mem_wr_en = 1'b1;
        bus.mem_wr_data = 8'hEE;
        #1;
        chk("full_stall_a", 32'(bus.stall), 32'h1);
        tick();
        chk("full_stall_b", 32'(bus.stall), 32'h1);
        chk("full_head", 32'(ch_data(1)), 32'hAA);
        bus.out_ready = 2'b10;
        #1;
        chk("full_stall_pop", 32'(bus.stall), 32'h1);
        tick();
        bus.out_ready = 2'b00;
        #1;
        chk("stall_release", 32'(bus.stall), 32'h0);
        chk("head_after_pop", 32'(ch_data(1)), 32'hBB);
        tick();
        bus.mem_wr_en = 1'b0;
        rd_chk("ch1_full_again", 8'hFA, 8'h02);
        bus.out_ready = 2'b10;
        #1; chk("ch1_order0", 32'(ch_data(1)), 32'hBB); tick();
        chk("ch1_order1", 32'(ch_data(1)), 32'hCC); tick();
        chk("ch1_order2", 32'(ch_data(1)), 32'hDD); tick();
        chk("ch1_order3", 32'(ch_data(1)), 32'hEE); tick();
        chk("ch1_drained", 32'(bus.out_valid), 32'h0);
        bus.out_ready = 2'b00;

        // RAM pass-through and decode
        bus.mem_addr = 8'h10;
        bus.mem_wr_en = 1'b1;
        bus.mem_wr_data = 8'h5A;
        #1;
        chk("ram_wr_en", 32'(bus.ram_wr_en), 32'h1);
        chk("ram_stall", 32'(bus.stall), 32'h0);
        chk("ram_rd", 32'(bus.mem_rd_data), 32'hC3);
        bus.mem_addr = 8'hFA;
        #1;
        chk("status_wr_stall", 32'(bus.stall), 32'h0);
        chk("status_wr_ram", 32'(bus.ram_wr_en), 32'h0);
        tick();
        bus.mem_wr_en = 1'b0;
        rd_chk("status_unchanged", 8'hFB, 8'h03);
        rd_chk("chan_rd_zero", 8'hF8, 8'h00);
        rd_chk("ram_rd_f7", 8'hF7, 8'hC3);

        // interleaved push/pop on ch0 across pointer wrap
        bus.mem_addr = 8'hF8;
        for (int i = 0; i < 11; i++) begin
            bus.mem_wr_en   = s_push[i];
            bus.mem_wr_data = s_data[i];
            bus.out_ready   = {1'b0, s_rdy[i]};
            #1;
            chk($sformatf("il_valid%0d", i), 32'(bus.out_valid), 32'(s_val[i]));
            if (s_val[i]) chk($sformatf("il_head%0d", i), 32'(ch_data(0)), 32'(s_head[i]));
            if (s_push[i]) chk($sformatf("il_stall%0d", i), 32'(bus.stall), 32'h0);
            if (i == 7) begin
                bus.mem_addr = 8'hFA;
                #1;
                chk("il_full_reg", 32'(bus.mem_rd_data), 32'h01);
                bus.mem_addr = 8'hF8;
            end
            tick();
        end
        bus.mem_wr_en = 1'b0;
        bus.out_ready = 2'b00;
        #1;
        chk("il_drained", 32'(bus.out_valid), 32'h0);

        // asynchronous reset mid-operation
        bus.mem_wr_en = 1'b1;
        bus.mem_wr_data = 8'h61; tick();
        bus.mem_wr_data = 8'h62; tick();
        bus.mem_wr_data = 8'h63; tick();
        bus.mem_wr_data = 8'h99;
        #2;
        chk("pre_rst_valid", 32'(bus.out_valid), 32'h1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 32'(bus.out_valid), 32'h0);
        tick();
        bus.mem_wr_en = 1'b0;
        rd_chk("async_rst_empty", 8'hFB, 8'h03);
        rd_chk("async_rst_full", 8'hFA, 8'h00);
        chk("rst_push_ignored", 32'(bus.out_valid), 32'h0);
        rst = 1'b0;
        bus.mem_addr = 8'hF8;
        bus.mem_wr_en = 1'b1;
        bus.mem_wr_data = 8'h77;
        tick();
        bus.mem_wr_en = 1'b0;
        #1;
        chk("post_rst_valid", 32'(bus.out_valid), 32'h1);
        chk("post_rst_head", 32'(ch_data(0)), 32'h77);
        bus.out_ready = 2'b01;
        tick();
        bus.out_ready = 2'b00;
        #1;
        chk("post_rst_only", 32'(bus.out_valid), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mmio_ports.md
MMIO_PORTS -- requirements
Module: mmio_ports

Interface
REQ-001 Parameter DATA_W, default 8, data word width in bits.
REQ-002 Parameter ADDR_W, default 8, CPU data-address width in bits.
REQ-003 Parameter N_CH, default 2, number of output channels, range 1..8, never above DATA_W.
REQ-004 Parameter DEPTH, default 4, per-channel FIFO depth, power of two, at least 2.
REQ-005 Parameter BASE, default 8'hF8, first I/O address. BASE+N_CH+1 SHALL NOT exceed 2^ADDR_W-1.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  reset, asynchronous and active-high.
REQ-008 mem_addr  input  ADDR_W  CPU data address.
REQ-009 mem_wr_en  input  1  CPU write strobe.
REQ-010 mem_wr_data  input  DATA_W  CPU write data.
REQ-011 mem_rd_data  output  DATA_W  read data returned to the CPU.
REQ-012 ram_wr_en  output  1  write strobe forwarded to system RAM.
REQ-013 ram_rd_data  input  DATA_W  read data from system RAM.
REQ-014 stall  output  1  request to the CPU to hold the current instruction.
REQ-015 out_valid  output  N_CH  per-channel data-available flag.
REQ-016 out_data  output  N_CH*DATA_W  per-channel FIFO head data; channel c occupies bits [c*DATA_W +: DATA_W].
REQ-017 out_ready  input  N_CH  per-channel consumer accept.

Function
REQ-018 hit SHALL be true when BASE <= mem_addr <= BASE+N_CH+1; it is combinational.
REQ-019 ram_wr_en SHALL equal mem_wr_en AND NOT hit.
REQ-020 Channel address SHALL be BASE+c for channel c = 0..N_CH-1.
REQ-021 Address BASE+N_CH SHALL be the FULL status register: bit c = channel c full, upper bits 0, read-only.
REQ-022 Address BASE+N_CH+1 SHALL be the EMPTY status register: bit c = channel c empty, upper bits 0, read-only.
REQ-023 mem_rd_data SHALL be combinational:
- status register value when mem_addr is a status address;
- 0 when mem_addr is a channel address;
- ram_rd_data otherwise.
REQ-024 A write to channel c when it is not full SHALL push mem_wr_data into FIFO c at the clock edge; stall SHALL be 0.
REQ-025 A write to channel c when it is full SHALL assert stall combinationally in the same cycle and SHALL NOT push. This holds even if out_ready[c] pops in that same cycle.
REQ-026 stall SHALL be 0 in every other case.
REQ-027 Writes to status addresses SHALL be ignored and SHALL NOT stall.
REQ-028 out_valid[c] SHALL equal NOT empty[c]. out_data for channel c SHALL present the oldest entry; its value is undefined when empty.
REQ-029 A pop SHALL occur at the edge where out_valid[c] and out_ready[c] are both 1.
REQ-030 out_ready[c] while empty SHALL have no effect.
REQ-031 A push and a pop on the same non-full, non-empty channel in the same cycle SHALL both take effect; the occupancy count is unchanged.
REQ-032 A push and a pop on an empty channel in the same cycle: the push SHALL take effect; out_valid SHALL rise next cycle with the pushed data.
REQ-033 Each FIFO SHALL use read/write pointers of log2(DEPTH) bits wrapping modulo DEPTH, plus an occupancy count of log2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).
REQ-034 Channels SHALL be fully independent; activity on one channel SHALL NOT alter another channel's state or outputs.
REQ-035 FIFO ordering SHALL be strict first-in-first-out, with no loss or duplication across pointer wrap-around.

Reset
REQ-036 On rst=1, immediately and regardless of clk, all pointers and counts SHALL clear. Resulting outputs: out_valid=0, FULL=0, EMPTY = N_CH ones, stall=0 for any non-write input.
REQ-037 A reset asserted mid-operation SHALL discard all queued data; a push or pop in progress during reset SHALL NOT take effect.
REQ-038 FIFO storage SHALL NOT require reset; contents are don't-care while empty.
REQ-039 The first push SHALL be accepted at the first rising edge after rst deasserts.

Verification
REQ-040 Reset then idle, defaults (N_CH=2, DEPTH=4, BASE=F8) -> read FA returns 00, read FB returns 03, out_valid=00.
REQ-041 Write 11,22,33 to F8 with out_ready=0, then raise out_ready[0] -> out_data ch0 shows 11,22,33 on consecutive cycles; out_valid[0] drops after the third pop.
REQ-042 Fill ch1 with 4 writes to F9 -> FA reads 02. A 5th write asserts stall for every cycle until a pop; the write completes the cycle after stall drops; data order is preserved.
REQ-043 Write 5A to 10 and read 10 -> ram_wr_en=1, mem_rd_data=ram_rd_data, stall=0. Write to F8 -> ram_wr_en=0.
REQ-044 Push 7 and pop 7 words interleaved on ch0, with simultaneous push/pop cycles -> count never exceeds 4; the sequence is intact across pointer wrap.
REQ-045 With 3 entries queued, pulse rst asynchronously between edges -> out_valid goes to 0 immediately; FB reads 03; the next push is the only data seen.
